// File: rtl/mult_div_seq.sv
// Sequential signed multiply/divide unit: Booth radix-2 multiply, restoring
// divide on magnitudes, fixed 34-edge latency, results loaded into hi/lo on done.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    // state  | meaning
    // IDLE   | waiting for start; rejects DIV by zero with div_zero pulse
    // MULT   | one Booth iteration per cycle, 32 cycles
    // DIV    | one restoring-division bit per cycle, 32 cycles
    // FIX    | sign correction of quotient/remainder (MULT passes through)
    // DONE   | load hi/lo, pulse done, return to IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [5:0]       cnt;
    logic [WIDTH:0]   acc;       // one guard bit so a multiplicand of -2^31 cannot overflow
    logic [WIDTH-1:0] low;       // multiplier (MULT) or dividend/quotient (DIV)
    logic             q_m1;
    logic [WIDTH-1:0] m;         // multiplicand (MULT) or divisor magnitude (DIV)
    logic             is_div;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             reject_zero;
    logic             last_iter;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign last_iter = (cnt == 6'd31);
    assign a_mag     = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag     = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign m_ext     = {m[WIDTH-1], m};
    assign div_shift = {acc[WIDTH-1:0], low[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m};

    always_comb begin
        booth_sum = acc;
        case ({low[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        reject_zero = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!op) begin
                        state_next = S_MULT;
                        accept     = 1'b1;
                    end else if (b == '0) begin
                        reject_zero = 1'b1;
                    end else begin
                        state_next = S_DIV;
                        accept     = 1'b1;
                    end
                end
            end
            S_MULT:  if (last_iter) state_next = S_FIX;
            S_DIV:   if (last_iter) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            acc    <= '0;
            low    <= '0;
            q_m1   <= 1'b0;
            m      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        acc    <= '0;
                        q_m1   <= 1'b0;
                        is_div <= op;
                        if (!op) begin
                            low   <= b;
                            m     <= a;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else begin
                            low   <= a_mag;
                            m     <= b_mag;
                            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r <= a[WIDTH-1];
                        end
                    end
                end
                S_MULT: begin
                    acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    low  <= {booth_sum[0], low[WIDTH-1:1]};
                    q_m1 <= low[0];
                    cnt  <= last_iter ? 6'd0 : cnt + 6'd1;
                end
                S_DIV: begin
                    if (div_diff[WIDTH]) begin
                        acc <= div_shift;
                        low <= {low[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= div_diff;
                        low <= {low[WIDTH-2:0], 1'b1};
                    end
                    cnt <= last_iter ? 6'd0 : cnt + 6'd1;
                end
                S_FIX: begin
                    if (is_div) begin
                        if (neg_q) low <= ~low + 1'b1;
                        if (neg_r) acc <= {1'b0, ~acc[WIDTH-1:0] + 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            busy     <= (state_next != S_IDLE);
            done     <= (state == S_DONE);
            div_zero <= reject_zero;
            if (state == S_DONE) begin
                hi <= acc[WIDTH-1:0];
                lo <= low;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Randomized self-checking bench for mult_div_seq against a plain-arithmetic
// reference (64-bit signed product, truncating divide, dividend-signed remainder).
module tb_mult_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;
    logic [31:0] cur_hi = 32'h0;
    logic [31:0] cur_lo = 32'h0;

    mult_div_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl);
        longint sx, sy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p  = sx * sy;
            rh = p[63:32];
            rl = p[31:0];
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            rh = r[31:0];
            rl = q[31:0];
        end
    endtask

    // Issues one operation; noisy drives random start/op/a/b while busy.
    task automatic run_op(input bit o, input logic [31:0] x, input logic [31:0] y,
                          input bit noisy, input string tag);
        logic [31:0] eh, el;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = $urandom_range(0, 1);
        check({tag, ".hi_hold"}, {32'h0, hi}, {32'h0, cur_hi});
        check({tag, ".lo_hold"}, {32'h0, lo}, {32'h0, cur_lo});
        check({tag, ".done0"}, {63'h0, done}, 64'h0);
        if (o && y == 32'h0) begin
            check({tag, ".dz"}, {63'h0, div_zero}, 64'h1);
            check({tag, ".dz_busy"}, {63'h0, busy}, 64'h0);
            return;
        end
        check({tag, ".busy0"}, {63'h0, busy}, 64'h1);
        check({tag, ".nodz"}, {63'h0, div_zero}, 64'h0);
        model(o, x, y, eh, el);
        for (int k = 1; k <= 33; k++) begin
            if (noisy && k < 33) start = $urandom_range(0, 1);
            else start = 1'b0;
            @(posedge clk); #1;
            a = $urandom; b = $urandom; op = $urandom_range(0, 1);
            if (busy !== 1'b1 || done !== 1'b0) begin
                check({tag, ".busy_run"}, {62'h0, busy, done}, 64'h2);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, ".done"}, {63'h0, done}, 64'h1);
        check({tag, ".busy_end"}, {63'h0, busy}, 64'h0);
        check({tag, ".hi"}, {32'h0, hi}, {32'h0, eh});
        check({tag, ".lo"}, {32'h0, lo}, {32'h0, el});
        cur_hi = eh;
        cur_lo = el;
    endtask

    initial begin
        logic [31:0] eh, el, x, y;
        bit o, seen;
        reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        #1;
        check("rst.out", {29'h0, hi == 0, lo == 0, busy, done, div_zero}, {29'h0, 5'b11000});
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;

        run_op(1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, "mul_7x-3");
        run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, "mul_min2");
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mul_m1m1");
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, "div_-7/2");
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, "div_7/-2");
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_min/-1");
        run_op(1'b1, 32'd5, 32'h0, 1'b0, "div_zero");
        run_op(1'b0, 32'd3, 32'd4, 1'b0, "mul_after_dz");
        check("mul_3x4.lo", {32'h0, cur_lo}, 64'd12);

        // start held high; operands change at E5 and must be ignored
        x = 32'h00012345; y = 32'hFFFF0003;
        model(1'b0, x, y, eh, el);
        @(negedge clk); start = 1'b1; op = 1'b0; a = x; b = y;
        for (int k = 0; k <= 34; k++) begin
            @(posedge clk); #1;
            if (k == 4) begin a = 32'd9; b = 32'd11; end
        end
        check("hold.done", {63'h0, done}, 64'h1);
        check("hold.hi", {32'h0, hi}, {32'h0, eh});
        check("hold.lo", {32'h0, lo}, {32'h0, el});
        check("hold.busy34", {63'h0, busy}, 64'h0);
        @(posedge clk); #1;
        check("hold.accept35", {63'h0, busy}, 64'h1);
        start = 1'b0;
        model(1'b0, 32'd9, 32'd11, eh, el);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("hold.second_done", {63'h0, seen}, 64'h1);
        check("hold.second_lo", {32'h0, lo}, {32'h0, el});
        cur_hi = eh; cur_lo = el;

        // reset mid-DIV
        @(negedge clk); start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst.out", {29'h0, hi == 0, lo == 0, busy, done, div_zero}, {29'h0, 5'b11000});
        @(negedge clk); reset = 1'b1;
        cur_hi = 32'h0; cur_lo = 32'h0;
        run_op(1'b1, 32'd100, 32'd7, 1'b0, "div_100/7");
        check("div_100/7.q", {cur_hi, cur_lo}, {32'd2, 32'd14});

        for (int i = 0; i < 40; i++) begin
            o = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0: x = 32'h80000000;
                1: x = 32'hFFFFFFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: y = 32'hFFFFFFFF;
                2: y = $urandom_range(1, 15);
                default: y = $urandom;
            endcase
            run_op(o, x, y, 1'b1, $sformatf("rnd%0d_%s", i, o ? "div" : "mul"));
        end
        @(posedge clk); #1;
        check("final.done0", {63'h0, done}, 64'h0);
        check("final.idle", {63'h0, busy}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
